alu_result_stage: RTL and testbench

//  Registered output stage directly downstream of the ALU result mux (mux4x1).

---
 rtl/alu_result_stage_pkg.sv | 29 ++
 rtl/alu_result_stage_if.sv | 41 ++++
 rtl/alu_result_stage_flags.sv | 33 +++
 rtl/alu_result_stage.sv | 126 ++++++++++++
 tb/tb_alu_result_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_result_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_stage_pkg
//  Description : Shared op-select codes, stage state encoding and a helper
//                that tells which ops drive the adder's carry/overflow.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_result_stage_pkg;

    // ALU op select codes, as driven into the result mux
    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;
    localparam logic [1:0] SEL_SLT = 2'b11;

    // Skid-buffer occupancy states
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    // Only ADD and SLT go through the adder, so only they own carry/overflow
    function automatic logic sel_uses_adder(input logic [1:0] sel);
        return (sel == SEL_ADD) || (sel == SEL_SLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_stage_if
//  Description : Valid/ready bundle between the ALU mux, the result stage and
//                its consumer. The master side feeds results in and accepts
//                them out; the slave side is the stage itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_result_stage_if #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_result;
    logic [1:0]           in_sel;
    logic                 in_carry;
    logic                 in_ovf;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_result;
    logic [1:0]           out_sel;
    logic                 out_zero;
    logic                 out_neg;
    logic                 out_carry;
    logic                 out_ovf;
    logic [CNT_WIDTH-1:0] xfer_count;

    modport master (
        output in_valid, in_result, in_sel, in_carry, in_ovf, out_ready,
        input  in_ready, out_valid, out_result, out_sel, out_zero, out_neg,
               out_carry, out_ovf, xfer_count
    );

    modport slave (
        input  in_valid, in_result, in_sel, in_carry, in_ovf, out_ready,
        output in_ready, out_valid, out_result, out_sel, out_zero, out_neg,
               out_carry, out_ovf, xfer_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_result_stage_flags.sv
`default_nettype none
// ============================================================================
//  Module      : alu_flags
//  Description : Combinational status flags for an ALU result: zero, sign,
//                and carry/overflow masked to the ops that use the adder.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_flags
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  wire logic [WIDTH-1:0] i_result,
    input  wire logic [1:0]       i_sel,
    input  wire logic             i_carry,
    input  wire logic             i_ovf,
    output logic                  o_zero,
    output logic                  o_neg,
    output logic                  o_carry_m,
    output logic                  o_ovf_m
);
    logic w_adder_op;

    // Carry/overflow from the adder are meaningless for logical ops
    always_comb begin
        w_adder_op = sel_uses_adder(i_sel);
        o_zero     = ~|i_result;
        o_neg      = i_result[WIDTH-1];
        o_carry_m  = i_carry & w_adder_op;
        o_ovf_m    = i_ovf & w_adder_op;
    end
endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_stage
//  Description : Registered ALU result stage with a 2-entry skid buffer.
//                Payload and flags are captured on accept and presented on a
//                valid/ready output; in_ready is registered so the upstream
//                path is cut, and the skid entry keeps full throughput.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_result_stage_if.slave  bus
);
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [1:0]       sel;
        logic             zero;
        logic             neg;
        logic             carry;
        logic             ovf;
    } payload_t;

    payload_t             w_new;
    logic                 w_accept;
    logic                 w_deliver;

    state_t               state_q,      state_d;
    payload_t             main_q,       main_d;
    payload_t             skid_q,       skid_d;
    logic                 in_ready_q,   in_ready_d;
    logic                 out_valid_q,  out_valid_d;
    logic [CNT_WIDTH-1:0] xfer_count_q, xfer_count_d;

    alu_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .i_result  (bus.in_result),
        .i_sel     (bus.in_sel),
        .i_carry   (bus.in_carry),
        .i_ovf     (bus.in_ovf),
        .o_zero    (w_new.zero),
        .o_neg     (w_new.neg),
        .o_carry_m (w_new.carry),
        .o_ovf_m   (w_new.ovf)
    );

    assign w_new.result = bus.in_result;
    assign w_new.sel    = bus.in_sel;

    // Next-state, payload movement and counter update for one handshake cycle
    always_comb begin
        w_accept     = bus.in_valid & in_ready_q;
        w_deliver    = out_valid_q & bus.out_ready;
        state_d      = state_q;
        main_d       = main_q;
        skid_d       = skid_q;
        xfer_count_d = xfer_count_q + CNT_WIDTH'(w_deliver);

        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    main_d  = w_new;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_accept && w_deliver) begin
                    main_d = w_new;
                end else if (w_accept) begin
                    skid_d  = w_new;
                    state_d = ST_FULL;
                end else if (w_deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain direction can move
                if (w_deliver) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State, payload and handshake registers; reset drops any buffered data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = main_q.result;
    assign bus.out_sel    = main_q.sel;
    assign bus.out_zero   = main_q.zero;
    assign bus.out_neg    = main_q.neg;
    assign bus.out_carry  = main_q.carry;
    assign bus.out_ovf    = main_q.ovf;
    assign bus.xfer_count = xfer_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_stage
//  Description : Self-checking bench for alu_result_stage (WIDTH=32,
//                CNT_WIDTH=4). A FIFO-of-depth-2 reference model predicts
//                every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_result_stage;
    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 4;

    typedef struct {
        logic [31:0] result;
        logic [1:0]  sel;
        logic        zero;
        logic        neg;
        logic        carry;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;

    alu_result_stage_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    alu_result_stage #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t mq[$];
    logic m_ready;
    logic [3:0] m_count;
    logic m_clean;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic [1:0] s,
                                input logic c, input logic o);
        exp_t e;
        logic adder_op;
        adder_op = (s == 2'd2) || (s == 2'd3);
        e.result = r;
        e.sel    = s;
        e.zero   = (r == 32'd0);
        e.neg    = (r >= 32'h8000_0000);
        e.carry  = c && adder_op;
        e.ovf    = o && adder_op;
        return e;
    endfunction

    // Check current outputs, advance the model with current inputs, clock once
    task automatic step();
        exp_t h;
        logic acc, del;
        chk_eq("out_valid",  bus.out_valid,  mq.size() > 0);
        chk_eq("in_ready",   bus.in_ready,   m_ready);
        chk_eq("xfer_count", bus.xfer_count, m_count);
        if (mq.size() > 0) begin
            h = mq[0];
            chk_eq("out_result", bus.out_result, h.result);
            chk_eq("out_sel",    bus.out_sel,    h.sel);
            chk_eq("out_zero",   bus.out_zero,   h.zero);
            chk_eq("out_neg",    bus.out_neg,    h.neg);
            chk_eq("out_carry",  bus.out_carry,  h.carry);
            chk_eq("out_ovf",    bus.out_ovf,    h.ovf);
        end else if (m_clean) begin
            chk_eq("reset_payload", {bus.out_result, bus.out_sel, bus.out_zero,
                   bus.out_neg, bus.out_carry, bus.out_ovf}, 64'd0);
        end

        if (!rst_n) begin
            mq.delete();
            m_ready = 1'b0;
            m_count = 4'd0;
            m_clean = 1'b1;
        end else begin
            acc = bus.in_valid && m_ready;
            del = (mq.size() > 0) && bus.out_ready;
            if (del) begin
                void'(mq.pop_front());
                m_count = m_count + 4'd1;
            end
            if (acc) begin
                mq.push_back(mk(bus.in_result, bus.in_sel, bus.in_carry, bus.in_ovf));
                m_clean = 1'b0;
            end
            m_ready = (mq.size() < 2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [1:0] s,
                         input logic c, input logic o);
        bus.in_valid  = v;
        bus.in_result = r;
        bus.in_sel    = s;
        bus.in_carry  = c;
        bus.in_ovf    = o;
    endtask

    initial begin
        logic [31:0] d;
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h1234, 2'd2, 1'b1, 1'b1);
        mq.delete();
        m_ready = 1'b0;
        m_count = 4'd0;
        m_clean = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with in_valid asserted
        repeat (3) step();
        rst_n = 1'b1;
        step();
        step();

        // Back-to-back streaming with out_ready high
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h5, 2'd0, 1'b0, 1'b0);          step();
        drive(1'b1, 32'h0, 2'd1, 1'b0, 1'b0);          step();
        drive(1'b1, 32'h8000_0000, 2'd2, 1'b1, 1'b0);  step();
        drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        repeat (2) step();

        // Backpressure: A on out, B in skid, C held off then drained in order
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h11, 2'd0, 1'b0, 1'b0); step();
        drive(1'b1, 32'h22, 2'd1, 1'b0, 1'b0); step();
        drive(1'b1, 32'h33, 2'd3, 1'b1, 1'b1);
        repeat (3) step();
        bus.out_ready = 1'b1;
        repeat (2) step();
        drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        repeat (3) step();

        // Flag masking
        drive(1'b1, 32'hFFFF_FFFF, 2'd1, 1'b1, 1'b1); step();
        drive(1'b1, 32'h7FFF_FFFF, 2'd2, 1'b1, 1'b1); step();
        drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        repeat (2) step();

        // Counter wrap: a long stream pushes the 4-bit count through 15 -> 0
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            step();
        end
        drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        repeat (2) step();

        // Reset while FULL, then a single 0x7 afterwards
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hAA, 2'd0, 1'b0, 1'b0); step();
        drive(1'b1, 32'hBB, 2'd0, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);  step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h7, 2'd2, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        repeat (3) step();

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       d = 32'd0;
                1:       d = 32'h8000_0000 | $urandom;
                default: d = $urandom;
            endcase
            drive(($urandom_range(0, 3) != 0), d, 2'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
